// File: rtl/i2c_read_arbiter.sv
// Round-robin arbiter sharing one I2C read master among N_REQ requesters.
// Optional WAIT-state timeout is enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_read_arbiter #(
    parameter int N_REQ       = 3,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic                 clk_50mhz,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   req_slave_addr,
    input  logic [8*N_REQ-1:0]   req_reg_addr,
    output logic [N_REQ-1:0]     gnt,
    output logic [N_REQ-1:0]     rsp_valid,
    output logic [7:0]           rsp_data,
    output logic                 rsp_err,
    output logic                 m_start,
    output logic [7:0]           m_slave_addr,
    output logic [7:0]           m_reg_addr,
    input  logic                 m_busy,
    input  logic                 m_done,
    input  logic                 m_ack_err,
    input  logic [7:0]           m_data
);

    // state | meaning
    // IDLE  | no transaction; pick next requester round-robin
    // ISSUE | owner granted; waiting for master idle to pulse m_start
    // WAIT  | master running; waiting for m_done (or timeout)
    // RESP  | rsp_valid pulsing to owner; release grant
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t             state_q;
    logic [IDX_W-1:0]   last_q;
    logic [IDX_W-1:0]   owner_q;
    logic [N_REQ-1:0]   gnt_q;
    logic [N_REQ-1:0]   rsp_valid_q;
    logic [7:0]         rsp_data_q;
    logic               rsp_err_q;
    logic               m_start_q;
    logic [7:0]         m_slave_addr_q;
    logic [7:0]         m_reg_addr_q;

    logic [IDX_W-1:0]   cand;
    logic [IDX_W-1:0]   pick_idx_d;
    logic               pick_found_d;
    logic [N_REQ-1:0]   pick_onehot_d;
    logic [7:0]         sel_slave_d;
    logic [7:0]         sel_reg_d;
    logic               to_hit;

    // Search starts one past the last served requester and wraps at N_REQ-1.
    always_comb begin
        cand         = last_q;
        pick_idx_d   = last_q;
        pick_found_d = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = (cand == IDX_W'(N_REQ - 1)) ? '0 : cand + 1'b1;
            if (!pick_found_d && req[cand]) begin
                pick_found_d = 1'b1;
                pick_idx_d   = cand;
            end
        end
    end

    always_comb begin
        pick_onehot_d = '0;
        sel_slave_d   = '0;
        sel_reg_d     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_idx_d == IDX_W'(i)) begin
                pick_onehot_d[i] = 1'b1;
                sel_slave_d      = req_slave_addr[8*i +: 8];
                sel_reg_d        = req_reg_addr[8*i +: 8];
            end
        end
    end

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] to_cnt_q;

    // Down-counter loaded as the master is started; terminal count ends WAIT.
    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            to_cnt_q <= '0;
        end else if (state_q == ISSUE && !m_busy) begin
            to_cnt_q <= TO_W'(TIMEOUT_CYC - 1);
        end else if (state_q == WAIT && to_cnt_q != '0) begin
            to_cnt_q <= to_cnt_q - 1'b1;
        end
    end

    assign to_hit = (state_q == WAIT) && (to_cnt_q == '0);
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            last_q         <= IDX_W'(N_REQ - 1);
            owner_q        <= '0;
            gnt_q          <= '0;
            rsp_valid_q    <= '0;
            rsp_data_q     <= '0;
            rsp_err_q      <= 1'b0;
            m_start_q      <= 1'b0;
            m_slave_addr_q <= '0;
            m_reg_addr_q   <= '0;
        end else begin
            m_start_q   <= 1'b0;
            rsp_valid_q <= '0;
            case (state_q)
                IDLE: begin
                    if (pick_found_d) begin
                        owner_q        <= pick_idx_d;
                        gnt_q          <= pick_onehot_d;
                        m_slave_addr_q <= sel_slave_d;
                        m_reg_addr_q   <= sel_reg_d;
                        state_q        <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!m_busy) begin
                        m_start_q <= 1'b1;
                        state_q   <= WAIT;
                    end
                end
                WAIT: begin
                    // m_done takes precedence over a coincident timeout
                    if (m_done) begin
                        rsp_data_q  <= m_data;
                        rsp_err_q   <= m_ack_err;
                        rsp_valid_q <= gnt_q;
                        state_q     <= RESP;
                    end else if (to_hit) begin
                        rsp_data_q  <= 8'hFF;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= gnt_q;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    gnt_q   <= '0;
                    last_q  <= owner_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt          = gnt_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_err      = rsp_err_q;
    assign m_start      = m_start_q;
    assign m_slave_addr = m_slave_addr_q;
    assign m_reg_addr   = m_reg_addr_q;

endmodule

// File: tb/tb_i2c_read_arbiter.sv
// Bench for i2c_read_arbiter: directed scenarios plus randomized traffic checked
// every cycle against a transaction-level model (timeout part under I2C_ARB_TIMEOUT_EN).
module tb_i2c_read_arbiter;

    localparam int N  = 3;
    localparam int TO = 100;
`ifdef I2C_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic           clk_50mhz = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [8*N-1:0] req_slave_addr = '0;
    logic [8*N-1:0] req_reg_addr = '0;
    logic [N-1:0]   gnt;
    logic [N-1:0]   rsp_valid;
    logic [7:0]     rsp_data;
    logic           rsp_err;
    logic           m_start;
    logic [7:0]     m_slave_addr;
    logic [7:0]     m_reg_addr;
    logic           m_busy = 1'b0;
    logic           m_done = 1'b0;
    logic           m_ack_err = 1'b0;
    logic [7:0]     m_data = '0;

    i2c_read_arbiter #(.N_REQ(N), .TIMEOUT_CYC(TO)) dut (
        .clk_50mhz(clk_50mhz), .rst(rst), .req(req),
        .req_slave_addr(req_slave_addr), .req_reg_addr(req_reg_addr),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .m_start(m_start), .m_slave_addr(m_slave_addr), .m_reg_addr(m_reg_addr),
        .m_busy(m_busy), .m_done(m_done), .m_ack_err(m_ack_err), .m_data(m_data)
    );

    always #10 clk_50mhz = ~clk_50mhz;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: who owns the master, whether it has been started,
    // how long it has been running, and whether the completion is being reported.
    int           mdl_owner;
    int           mdl_last;
    int           mdl_wait;
    bit           mdl_started;
    bit           mdl_release;
    logic [N-1:0] e_gnt;
    logic [N-1:0] e_rsp_valid;
    logic [7:0]   e_rsp_data;
    logic         e_rsp_err;
    logic         e_m_start;
    logic [7:0]   e_slave;
    logic [7:0]   e_reg;

    task automatic model_reset();
        mdl_owner = -1; mdl_last = N - 1; mdl_wait = 0;
        mdl_started = 1'b0; mdl_release = 1'b0;
        e_gnt = '0; e_rsp_valid = '0; e_rsp_data = '0; e_rsp_err = 1'b0;
        e_m_start = 1'b0; e_slave = '0; e_reg = '0;
    endtask

    task automatic finish_txn(input logic [7:0] d, input logic e);
        e_rsp_data  = d;
        e_rsp_err   = e;
        e_rsp_valid = N'(1) << mdl_owner;
        mdl_release = 1'b1;
    endtask

    task automatic model_step();
        int  c;
        bit  found;
        e_m_start   = 1'b0;
        e_rsp_valid = '0;
        if (mdl_release) begin
            e_gnt       = '0;
            mdl_last    = mdl_owner;
            mdl_owner   = -1;
            mdl_release = 1'b0;
        end else if (mdl_owner < 0) begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                c = (mdl_last + k) % N;
                if (!found && req[c]) begin
                    found     = 1'b1;
                    mdl_owner = c;
                end
            end
            if (found) begin
                e_gnt       = N'(1) << mdl_owner;
                e_slave     = req_slave_addr[8*mdl_owner +: 8];
                e_reg       = req_reg_addr[8*mdl_owner +: 8];
                mdl_started = 1'b0;
            end
        end else if (!mdl_started) begin
            if (!m_busy) begin
                e_m_start   = 1'b1;
                mdl_started = 1'b1;
                mdl_wait    = 0;
            end
        end else begin
            if (m_done) begin
                finish_txn(m_data, m_ack_err);
            end else if (TO_EN) begin
                mdl_wait++;
                if (mdl_wait == TO) finish_txn(8'hFF, 1'b1);
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk_50mhz or posedge rst);
            if (rst) model_reset();
            else     model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk_50mhz);
            check("gnt",          32'(gnt),          32'(e_gnt));
            check("rsp_valid",    32'(rsp_valid),    32'(e_rsp_valid));
            check("rsp_data",     32'(rsp_data),     32'(e_rsp_data));
            check("rsp_err",      32'(rsp_err),      32'(e_rsp_err));
            check("m_start",      32'(m_start),      32'(e_m_start));
            check("m_slave_addr", 32'(m_slave_addr), 32'(e_slave));
            check("m_reg_addr",   32'(m_reg_addr),   32'(e_reg));
        end
    end

    task automatic tick();
        @(posedge clk_50mhz);
        #1;
    endtask

    task automatic wait_start(input string name);
        int n;
        n = 0;
        while (m_start !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check(name, 32'(m_start), 32'd1);
    endtask

    task automatic done_pulse(input logic [7:0] d, input logic e);
        m_done = 1'b1; m_data = d; m_ack_err = e;
        tick();
        m_done = 1'b0; m_ack_err = 1'b0;
    endtask

    bit  outstanding;
    int  lat;
    bit  seen;
    int  n;

    initial begin
        // reset values
        repeat (3) tick();
        check("rst_gnt",   32'(gnt),          32'd0);
        check("rst_valid", 32'(rsp_valid),    32'd0);
        check("rst_start", 32'(m_start),      32'd0);
        check("rst_slave", 32'(m_slave_addr), 32'd0);
        rst = 1'b0;
        tick();

        // single request, latency and data path
        req_slave_addr[7:0] = 8'h68; req_reg_addr[7:0] = 8'h3B;
        req = 3'b001;
        tick();
        check("lat1_gnt",   32'(gnt),     32'h1);
        check("lat1_start", 32'(m_start), 32'd0);
        tick();
        check("lat2_start", 32'(m_start),      32'd1);
        check("lat2_slave", 32'(m_slave_addr), 32'h68);
        check("lat2_reg",   32'(m_reg_addr),   32'h3B);
        repeat (49) tick();
        done_pulse(8'hA5, 1'b0);
        check("a_valid", 32'(rsp_valid), 32'h1);
        check("a_data",  32'(rsp_data),  32'hA5);
        check("a_err",   32'(rsp_err),   32'd0);
        req = '0;
        tick();
        check("a_release", 32'(gnt),      32'd0);
        check("a_hold",    32'(rsp_data), 32'hA5);
        tick();

        // all three requesting from a fresh pointer
        rst = 1'b1; tick(); rst = 1'b0; tick();
        req_slave_addr = {8'h52, 8'h51, 8'h50};
        req_reg_addr   = {8'h12, 8'h11, 8'h10};
        req = 3'b111;
        for (int t = 0; t < 3; t++) begin
            wait_start("rr_start");
            check("rr_gnt", 32'(gnt), 32'(1) << t);
            repeat (3) tick();
            done_pulse(8'(8'h20 + t), 1'b0);
            check("rr_valid", 32'(rsp_valid), 32'(1) << t);
            check("rr_valid_gnt", 32'(rsp_valid), 32'(gnt));
        end
        req = '0;
        repeat (2) tick();

        // master busy holds off the start
        m_busy = 1'b1;
        req = 3'b010;
        tick();
        seen = 1'b0;
        for (int t = 0; t < 19; t++) begin
            tick();
            if (m_start) seen = 1'b1;
        end
        check("busy_holdoff", 32'(seen), 32'd0);
        m_busy = 1'b0;
        tick();
        check("busy_release_start", 32'(m_start), 32'd1);
        tick();
        check("start_one_cycle", 32'(m_start), 32'd0);
        done_pulse(8'h77, 1'b0);
        check("busy_valid", 32'(rsp_valid), 32'h2);
        req = '0;
        repeat (2) tick();

        // NACK then normal service for the next requester
        req = 3'b101;
        wait_start("nack_start");
        check("nack_gnt", 32'(gnt), 32'h4);
        done_pulse(8'h3C, 1'b1);
        check("nack_valid", 32'(rsp_valid), 32'h4);
        check("nack_err",   32'(rsp_err),   32'd1);
        check("nack_data",  32'(rsp_data),  32'h3C);
        req = 3'b001;
        wait_start("next_start");
        check("next_gnt", 32'(gnt), 32'h1);
        done_pulse(8'h5A, 1'b0);
        check("next_valid", 32'(rsp_valid), 32'h1);
        check("next_err",   32'(rsp_err),   32'd0);
        req = '0;
        repeat (2) tick();

        // reset while waiting, then stray m_done, then tie 0 vs 2
        req = 3'b001;
        wait_start("rw_start");
        repeat (3) tick();
        rst = 1'b1;
        #1;
        check("rw_gnt",   32'(gnt),          32'd0);
        check("rw_data",  32'(rsp_data),     32'd0);
        check("rw_err",   32'(rsp_err),      32'd0);
        check("rw_slave", 32'(m_slave_addr), 32'd0);
        m_done = 1'b1; m_data = 8'hEE;
        tick();
        m_done = 1'b0;
        check("rw_no_valid1", 32'(rsp_valid), 32'd0);
        tick();
        check("rw_no_valid2", 32'(rsp_valid), 32'd0);
        rst = 1'b0;
        req = 3'b101;
        tick();
        check("rw_tie_gnt", 32'(gnt), 32'h1);
        wait_start("rw_tie_start");
        done_pulse(8'h11, 1'b0);
        req = '0;
        repeat (2) tick();

`ifdef I2C_ARB_TIMEOUT_EN
        req = 3'b010;
        wait_start("to_start");
        n = 0;
        while (rsp_valid == '0 && n < 300) begin
            tick();
            n++;
        end
        check("to_cycles", 32'(n),         32'd100);
        check("to_valid",  32'(rsp_valid), 32'h2);
        check("to_data",   32'(rsp_data),  32'hFF);
        check("to_err",    32'(rsp_err),   32'd1);
        req = '0;
        repeat (2) tick();
`endif

        // randomized traffic
        outstanding = 1'b0;
        lat = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (req[i]) begin
                    if (rsp_valid[i]) req[i] = 1'b0;
                    else if (gnt[i] && $urandom_range(99) < 3) req[i] = 1'b0;
                end else if (cyc < 2800 && $urandom_range(99) < 15) begin
                    req[i] = 1'b1;
                    req_slave_addr[8*i +: 8] = 8'($urandom);
                    req_reg_addr[8*i +: 8]   = 8'($urandom);
                end
            end
            m_done = 1'b0;
            m_ack_err = 1'b0;
            if (cyc == 1500) begin
                rst = 1'b1;
                outstanding = 1'b0;
            end else if (cyc == 1503) begin
                rst = 1'b0;
            end
            if (m_start) begin
                outstanding = 1'b1;
                lat = $urandom_range(1, 20);
            end else if (outstanding) begin
                lat--;
                if (lat == 0) begin
                    m_done      = 1'b1;
                    m_data      = 8'($urandom);
                    m_ack_err   = ($urandom_range(9) == 0);
                    outstanding = 1'b0;
                end
            end else if ($urandom_range(99) < 2) begin
                m_done = 1'b1;
                m_data = 8'($urandom);
            end
            m_busy = outstanding ? 1'b1 : ($urandom_range(99) < 30);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_read_arbiter.md
I2C_READ_ARBITER -- requirements
Module: i2c_read_arbiter

Interface
REQ-001 Parameter N_REQ, default 3: number of requesters sharing one I2C read master (2..8).
REQ-002 Parameter TIMEOUT_CYC, default 200000: clk_50mhz cycles allowed in WAIT before abort (4 ms).
REQ-003 clk_50mhz  input  1  50 MHz system clock; all logic on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req  input  N_REQ  per-requester read request level; held until matching rsp_valid.
REQ-006 req_slave_addr  input  8*N_REQ  packed slave addresses; requester i uses bits [8i+7:8i].
REQ-007 req_reg_addr  input  8*N_REQ  packed register addresses, same packing.
REQ-008 gnt  output  N_REQ  one-hot grant; set for the owner of the in-flight transaction.
REQ-009 rsp_valid  output  N_REQ  one-cycle completion pulse to the owner.
REQ-010 rsp_data  output  8  read data; valid while rsp_valid is nonzero.
REQ-011 rsp_err  output  1  NACK or timeout flag; valid while rsp_valid is nonzero.
REQ-012 m_start  output  1  one-cycle start pulse to the I2C master.
REQ-013 m_slave_addr, m_reg_addr  output  8 each  addresses presented to the master; stable from m_start until m_done.
REQ-014 m_busy  input  1  master busy; the arbiter issues no start while it is high.
REQ-015 m_done  input  1  master one-cycle completion pulse.
REQ-016 m_ack_err  input  1  master NACK indication; sampled with m_done.
REQ-017 m_data  input  8  master read data; sampled with m_done.

Function
REQ-018 FSM states: IDLE, ISSUE, WAIT, RESP; all outputs registered.
REQ-019 IDLE: when req != 0, select a requester by round-robin, searching from (last+1) mod N_REQ upward; latch its addresses into m_slave_addr/m_reg_addr; set gnt; go to ISSUE.
REQ-020 ISSUE: when m_busy = 0, pulse m_start for exactly one cycle and go to WAIT; otherwise stay in ISSUE with m_start = 0.
REQ-021 WAIT: on m_done, capture m_data into rsp_data and m_ack_err into rsp_err, then go to RESP.
REQ-022 RESP: pulse rsp_valid[owner] for one cycle, clear gnt, set last = owner, return to IDLE.
REQ-023 Latency: 2 cycles minimum from req rising in IDLE to m_start; 1 cycle from m_done to rsp_valid.
REQ-024 A requester dropping req while granted does not abort; the transaction completes and rsp_valid is still pulsed.
REQ-025 A request arriving during a transaction waits; only one transaction is in flight.
REQ-026 m_done outside WAIT is ignored.
REQ-027 Simultaneous requests: the highest-priority requester under the rotating pointer wins; with all N_REQ held continuously, grants cycle 0,1,2,0...
REQ-028 The pointer wraps from N_REQ-1 to 0.
REQ-029 rsp_data and rsp_err hold their value until the next capture.

Reset
REQ-030 While rst = 1: state = IDLE; gnt = 0; rsp_valid = 0; rsp_data = 0; rsp_err = 0; m_start = 0; m_slave_addr = 0; m_reg_addr = 0; last = N_REQ-1 (so requester 0 has first priority); timeout counter = 0.
REQ-031 Reset during ISSUE or WAIT aborts silently; no rsp_valid is pulsed for the aborted transaction.

Configuration
REQ-032 Macro I2C_ARB_TIMEOUT_EN, when defined: a counter runs in WAIT; on reaching TIMEOUT_CYC without m_done, go to RESP with rsp_err = 1 and rsp_data = 8'hFF.
REQ-033 Without I2C_ARB_TIMEOUT_EN: WAIT exits only on m_done; no counter logic is synthesized.

Verification
REQ-034 req = 3'b001, addr 8'h68/8'h3B, m_done after 50 cycles with m_data = 8'hA5 and m_ack_err = 0 -> m_start 2 cycles after req; rsp_valid = 3'b001; rsp_data = A5; rsp_err = 0.
REQ-035 req = 3'b111 held for 3 transactions -> gnt sequence 001, 010, 100; each rsp_valid matches its gnt.
REQ-036 m_busy = 1 for 20 cycles at ISSUE -> m_start is held off and pulses in the first cycle after m_busy falls.
REQ-037 m_done with m_ack_err = 1 -> rsp_err = 1 with rsp_valid; the next requester is served normally.
REQ-038 With I2C_ARB_TIMEOUT_EN and TIMEOUT_CYC = 100, no m_done -> rsp_valid at cycle 101 of WAIT with rsp_err = 1 and rsp_data = FF.
REQ-039 rst asserted in WAIT, then m_done pulsed -> all outputs 0, no rsp_valid; after release, requester 0 wins a tie with requester 2.
